// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown-timer controller: FSM state encoding,
// the largest displayable count, default timebase frequencies and the load
// saturation helper.
// ----------------------------------------------------------------------------
package timer_pkg;

    // Encodings are visible on the state output port, so they are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // 999.9 s expressed in tenths of a second.
    localparam int unsigned MAX_COUNT = 9999;

    localparam int DEF_CLK_HZ  = 1_000_000;
    localparam int DEF_SCAN_HZ = 1_000;
    localparam int DEF_TICK_HZ = 10;

    // Keypad presets wider than the display can show are clamped.
    function automatic logic [31:0] sat_count(input logic [31:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

endpackage

// File: rtl/strobe_divider.sv
// ----------------------------------------------------------------------------
// strobe_divider
// Prescaler that produces a single-cycle enable strobe every DIV enabled
// cycles. Downstream logic stays on clk_in and qualifies on the strobe.
//
// Ports:
//   clk_in - system clock
//   rst    - synchronous, active-high reset (count to 0)
//   en     - count enable; the count holds while low
//   zero   - synchronous restart of the count to 0 (wins over en)
//   stb    - high while enabled and the count sits at DIV-1
// ----------------------------------------------------------------------------
module strobe_divider #(
    parameter int DIV = 1000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic zero,
    output logic stb
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LAST);

    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked block and is not in the sensitivity list.
    always_ff @(posedge clk_in) begin
        if (rst || zero) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

    assign stb = en && w_last;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// ----------------------------------------------------------------------------
// countdown_timer_ctrl
// Derives the 1 kHz scan strobe and the 10 Hz count tick from clk_in and runs
// a tenth-of-second countdown under keypad commands.
//
// Ports:
//   clk_in      - system clock (the only clock)
//   rst         - synchronous, active-high reset
//   load_valid  - one-cycle load command, preset in load_value (tenths)
//   start       - start/resume command
//   pause       - pause command
//   clear       - abort: return to IDLE with a zero count
//   scan_en     - free-running display-scan strobe
//   tick_en     - countdown tick strobe, only while running
//   remaining   - current count
//   state       - IDLE=0, RUN=1, PAUSE=2, DONE=3
//   done_pulse  - high during the first DONE cycle only
// ----------------------------------------------------------------------------
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int SCAN_HZ = DEF_SCAN_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ,
    parameter int CNT_W   = 14
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic             scan_en,
    output logic             tick_en,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state,
    output logic             done_pulse
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_remaining,  w_remaining_nxt;
    logic             r_done_pulse, w_done_pulse_nxt;

    logic             w_run;
    logic             w_tick_stb;
    logic             w_tick_zero;
    logic [CNT_W-1:0] w_load_sat;

    assign w_run      = (r_state == ST_RUN);
    assign w_load_sat = CNT_W'(sat_count(32'(load_value)));

    strobe_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (1'b1),
        .zero   (1'b0),
        .stb    (scan_en)
    );

    // Counts only in RUN so a pause/resume keeps the tick phase.
    strobe_divider #(.DIV(TICK_DIV)) u_tick_div (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (w_run),
        .zero   (w_tick_zero),
        .stb    (w_tick_stb)
    );

    // Commands are prioritised clear > pause > start > load; a command the
    // current state ignores does not mask a lower-priority one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_done_pulse_nxt = 1'b0;
        w_tick_zero      = 1'b0;

        if (clear) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
            w_tick_zero     = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start && (r_remaining != '0)) begin
                        w_state_nxt = ST_RUN;
                        w_tick_zero = 1'b1;
                    end else if (load_valid) begin
                        w_remaining_nxt = w_load_sat;
                        w_tick_zero     = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with pause still decrements; reaching
                    // zero takes precedence over pausing.
                    if (w_tick_stb && (r_remaining <= CNT_W'(1))) begin
                        w_remaining_nxt  = '0;
                        w_state_nxt      = ST_DONE;
                        w_done_pulse_nxt = 1'b1;
                    end else begin
                        if (w_tick_stb) begin
                            w_remaining_nxt = r_remaining - CNT_W'(1);
                        end
                        if (pause) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (load_valid) begin
                        w_state_nxt     = ST_IDLE;
                        w_remaining_nxt = w_load_sat;
                        w_tick_zero     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    assign tick_en    = w_tick_stb;
    assign remaining  = r_remaining;
    assign state      = r_state;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer_ctrl
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares them mid-cycle. Directed phases add
// timing checks against fixed values, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_countdown_timer_ctrl;

    localparam int CLK_HZ   = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int TICK_HZ  = 10;
    localparam int CNT_W    = 14;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    typedef struct packed {
        logic             scan;
        logic             tick;
        logic             done;
        logic [1:0]       st;
        logic [CNT_W-1:0] rem;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic [CNT_W-1:0] load_value = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             clear = 1'b0;
    logic             scan_en;
    logic             tick_en;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       state;
    logic             done_pulse;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t sb_q[$];
    obs_t obs;
    obs_t mon_exp;
    obs_t mon_act;
    int   ticks[$];

    // Reference model: mode 0..3, count, cycles since reset, RUN cycles since
    // the last restart of the tick timebase.
    bit m_valid = 0;
    int m_state = 0;
    int m_rem   = 0;
    int m_cyc   = 0;
    int m_run   = 0;
    bit m_done  = 0;

    countdown_timer_ctrl #(
        .CLK_HZ (CLK_HZ),
        .SCAN_HZ(SCAN_HZ),
        .TICK_HZ(TICK_HZ),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in    (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .scan_en   (scan_en),
        .tick_en   (tick_en),
        .remaining (remaining),
        .state     (state),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t model_outputs();
        obs_t o;
        o.scan = (m_cyc % SCAN_DIV) == SCAN_DIV - 1;
        o.tick = (m_state == 1) && ((m_run % TICK_DIV) == TICK_DIV - 1);
        o.done = m_done;
        o.st   = 2'(m_state);
        o.rem  = CNT_W'(m_rem);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit ld, input int lv, input bit st, input bit pa, input bit cl);
        bit tick;
        if (r) begin
            m_valid = 1; m_state = 0; m_rem = 0; m_cyc = 0; m_run = 0; m_done = 0;
            return;
        end
        if (!m_valid) return;
        tick = (m_state == 1) && ((m_run % TICK_DIV) == TICK_DIV - 1);
        if (m_state == 1) m_run++;
        m_cyc++;
        m_done = 0;
        if (cl) begin
            m_state = 0; m_rem = 0; m_run = 0;
        end else begin
            case (m_state)
                0: if (st && m_rem != 0) begin
                       m_state = 1; m_run = 0;
                   end else if (ld) begin
                       m_rem = (lv > 9999) ? 9999 : lv; m_run = 0;
                   end
                1: begin
                       if (tick) begin
                           m_rem = m_rem - 1;
                           if (m_rem == 0) begin m_state = 3; m_done = 1; end
                       end
                       if (pa && m_state == 1) m_state = 2;
                   end
                2: if (st) m_state = 1;
                default: if (ld) begin
                       m_rem = (lv > 9999) ? 9999 : lv; m_state = 0; m_run = 0;
                   end
            endcase
        end
    endtask

    // One clock cycle: drive at the falling edge, record the expectation,
    // advance the model, then capture the DUT outputs for directed checks.
    task automatic cycle(input bit r, input bit ld, input int lv, input bit st, input bit pa, input bit cl);
        @(negedge clk);
        rst = r; load_valid = ld; load_value = CNT_W'(lv);
        start = st; pause = pa; clear = cl;
        if (m_valid) sb_q.push_back(model_outputs());
        model_step(r, ld, lv & ((1 << CNT_W) - 1), st, pa, cl);
        #1;
        obs = {scan_en, tick_en, done_pulse, state, remaining};
    endtask

    task automatic idle();               cycle(0, 0, 0, 0, 0, 0); endtask
    task automatic cmd_load(input int v); cycle(0, 1, v, 0, 0, 0); endtask
    task automatic cmd_start();          cycle(0, 0, 0, 1, 0, 0); endtask
    task automatic cmd_pause();          cycle(0, 0, 0, 0, 1, 0); endtask
    task automatic cmd_clear();          cycle(0, 0, 0, 0, 0, 1); endtask

    function automatic int tick_at(input int i);
        return (i < ticks.size()) ? ticks[i] : -1;
    endfunction

    // Idle n cycles, recording the cycle index (1-based) of every tick_en.
    task automatic run_record(input int n, output int n_done);
        ticks.delete();
        n_done = 0;
        for (int k = 1; k <= n; k++) begin
            idle();
            if (obs.tick) ticks.push_back(k);
            n_done += int'(obs.done);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_act = {scan_en, tick_en, done_pulse, state, remaining};
            check("sb_cycle", 32'(mon_act), 32'(mon_exp));
        end
    end

    initial begin
        int n_scan;
        int n_tick;
        int n_done;
        int bad;

        // Reset, then 50 idle cycles.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        n_scan = 0; n_tick = 0;
        for (int k = 0; k < 50; k++) begin
            idle();
            n_scan += int'(obs.scan);
            n_tick += int'(obs.tick);
        end
        check("idle_scan_pulses", n_scan, 5);
        check("idle_tick_pulses", n_tick, 0);
        check("idle_state_rem", {obs.st, obs.rem}, 0);

        // Load 3, start: decrements at +100/+200/+300, then DONE.
        cmd_load(3);
        cmd_start();
        run_record(310, n_done);
        check("l3_tick_count", ticks.size(), 3);
        check("l3_tick0", tick_at(0), 100);
        check("l3_tick1", tick_at(1), 200);
        check("l3_tick2", tick_at(2), 300);
        check("l3_done_pulses", n_done, 1);
        check("l3_final", {obs.st, obs.rem}, {2'd3, 14'd0});

        // Load 5, start, pause at +150, hold 400, resume.
        cmd_clear();
        cmd_load(5);
        cmd_start();
        run_record(149, n_done);
        check("p_tick_before", tick_at(0), 100);
        cmd_pause();
        bad = 0;
        for (int k = 0; k < 400; k++) begin
            idle();
            if (obs.rem != 14'd4 || obs.st != 2'd2 || obs.tick) bad++;
        end
        check("p_hold_bad_cycles", bad, 0);
        check("p_hold_rem", obs.rem, 4);
        cmd_start();
        run_record(60, n_done);
        check("p_resume_tick", tick_at(0), 50);
        check("p_resume_rem", obs.rem, 3);

        // Saturating load; start with a zero count is ignored.
        cmd_clear();
        cmd_load(12000);
        idle();
        check("sat_load", obs.rem, 9999);
        cmd_clear();
        cmd_start();
        idle();
        check("start_zero_state", obs.st, 0);

        // Tick coinciding with pause: DONE wins.
        cmd_load(1);
        cmd_start();
        for (int k = 0; k < 99; k++) idle();
        cmd_pause();
        check("tp_tick_seen", obs.tick, 1);
        idle();
        check("tp_state", obs.st, 3);
        check("tp_done", obs.done, 1);
        idle();
        check("tp_done_once", obs.done, 0);

        // Tick coinciding with clear: clear wins.
        cmd_load(1);
        cmd_start();
        for (int k = 0; k < 99; k++) idle();
        cmd_clear();
        check("tc_tick_seen", obs.tick, 1);
        idle();
        check("tc_after", {obs.done, obs.st, obs.rem}, 0);

        // Reset while running with 7 left.
        cmd_load(7);
        cmd_start();
        for (int k = 0; k < 30; k++) idle();
        check("rr_running", {obs.st, obs.rem}, {2'd1, 14'd7});
        cycle(1, 0, 0, 0, 0, 0);
        idle();
        check("rr_reset_outputs", 32'(obs), 0);
        cmd_load(2);
        cmd_start();
        run_record(120, n_done);
        check("rr_first_tick", tick_at(0), 100);

        // Randomized commands, one at a time.
        for (int k = 0; k < 4000; k++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 199));
            v = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16383))
                                              : int'($urandom_range(1, 25));
            if (r < 4)       cmd_load(v);
            else if (r < 8)  cmd_start();
            else if (r < 10) cmd_pause();
            else if (r < 11) cmd_clear();
            else if (r == 11 && $urandom_range(0, 4) == 0) cycle(1, 0, 0, 0, 0, 0);
            else             idle();
        end

        idle();
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
